// File: rtl/pe_seq_ctrl.sv
// PE sequencer: streams ifmap/weights into the spads, clears psums, runs a hazard-free S*P MAC loop, then optionally accumulates upstream psums.
// All outputs registered (one cycle after the deciding state); stream readies are combinational; ACC issues only when upstream valid and downstream ready.
module pe_seq_ctrl #(
  parameter int IFMAP_ADDR_BITWIDTH = 4,
  parameter int WGHT_ADDR_BITWIDTH  = 7,
  parameter int PSUM_ADDR_BITWIDTH  = 3,
  parameter int PIPE_LAT            = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_start,
  input  logic [IFMAP_ADDR_BITWIDTH-1:0] i_cfg_s_m1,
  input  logic [PSUM_ADDR_BITWIDTH-1:0]  i_cfg_p_m1,
  input  logic                           i_cfg_wght_reuse,
  input  logic                           i_cfg_acc_en,
  input  logic                           i_ifmap_valid,
  output logic                           o_ifmap_ready,
  input  logic                           i_wght_valid,
  output logic                           o_wght_ready,
  input  logic                           i_psum_in_valid,
  output logic                           o_psum_in_ready,
  input  logic                           i_psum_out_ready,
  output logic                           o_ifmap_we,
  output logic                           o_wght_we,
  output logic                           o_psum_we,
  output logic [IFMAP_ADDR_BITWIDTH-1:0] o_ifmap_wa,
  output logic [IFMAP_ADDR_BITWIDTH-1:0] o_ifmap_ra,
  output logic [WGHT_ADDR_BITWIDTH-1:0]  o_wght_wa,
  output logic [WGHT_ADDR_BITWIDTH-1:0]  o_wght_ra,
  output logic [PSUM_ADDR_BITWIDTH-1:0]  o_psum_wa,
  output logic [PSUM_ADDR_BITWIDTH-1:0]  o_psum_ra,
  output logic                           o_acc_sel,
  output logic                           o_rst_psum,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_cfg_err
);
  localparam int IAB  = IFMAP_ADDR_BITWIDTH;
  localparam int WAB  = WGHT_ADDR_BITWIDTH;
  localparam int PAB  = PSUM_ADDR_BITWIDTH;
  localparam int SCW  = IAB + 1;
  localparam int PCW0 = PAB + 1;
  localparam int LCW  = $clog2(PIPE_LAT + 1);
  localparam int PCW  = (PCW0 > LCW) ? PCW0 : LCW;
  localparam int WCW  = WAB + 1;
  localparam int EW0  = SCW + PCW0;
  localparam int EW   = (EW0 > WCW) ? EW0 + 1 : WCW + 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_CLEAR, ST_MAC, ST_DRAIN, ST_ACC, ST_DRAIN2, ST_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [IAB-1:0] s_m1_q, s_m1_d;
  logic [PAB-1:0] p_m1_q, p_m1_d;
  logic           acc_en_q, acc_en_d;
  logic [WCW-1:0] wtgt_q, wtgt_d;
  logic [SCW-1:0] icnt_q, icnt_d;   // ifmap load count, then MAC s index
  logic [WCW-1:0] wcnt_q, wcnt_d;   // weight load count, then running weight read address
  logic [PCW-1:0] pcnt_q, pcnt_d;   // psum index / MAC slot
  logic [LCW-1:0] lcnt_q, lcnt_d;

  logic           ifmap_we_q, ifmap_we_d, wght_we_q, wght_we_d, psum_we_q, psum_we_d;
  logic [IAB-1:0] ifmap_wa_q, ifmap_wa_d, ifmap_ra_q, ifmap_ra_d;
  logic [WAB-1:0] wght_wa_q, wght_wa_d, wght_ra_q, wght_ra_d;
  logic [PAB-1:0] psum_addr_q, psum_addr_d;
  logic           acc_sel_q, acc_sel_d, rst_psum_q, rst_psum_d;
  logic           busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;

  logic [SCW-1:0] s_full, cfg_s;
  logic [PCW0-1:0] cfg_p;
  logic [EW-1:0]  cfg_prod;
  logic [PCW-1:0] p_last, slot_last;

  assign s_full    = SCW'(s_m1_q) + 1'b1;
  assign cfg_s     = SCW'(i_cfg_s_m1) + 1'b1;
  assign cfg_p     = PCW0'(i_cfg_p_m1) + 1'b1;
  assign cfg_prod  = EW'(cfg_s) * EW'(cfg_p);
  assign p_last    = PCW'(p_m1_q);
  // Short psum rows are padded so each psum is revisited no sooner than PIPE_LAT cycles later.
  assign slot_last = (p_last >= PCW'(PIPE_LAT - 1)) ? p_last : PCW'(PIPE_LAT - 1);

  assign o_ifmap_ready   = (state_q == ST_LOAD) && (icnt_q < s_full);
  assign o_wght_ready    = (state_q == ST_LOAD) && (wcnt_q < wtgt_q);
  assign o_psum_in_ready = (state_q == ST_ACC) && i_psum_in_valid && i_psum_out_ready;

  always_comb begin
    state_d     = state_q;
    s_m1_d      = s_m1_q;
    p_m1_d      = p_m1_q;
    acc_en_d    = acc_en_q;
    wtgt_d      = wtgt_q;
    icnt_d      = icnt_q;
    wcnt_d      = wcnt_q;
    pcnt_d      = pcnt_q;
    lcnt_d      = lcnt_q;
    ifmap_we_d  = 1'b0;
    ifmap_wa_d  = '0;
    ifmap_ra_d  = '0;
    wght_we_d   = 1'b0;
    wght_wa_d   = '0;
    wght_ra_d   = '0;
    psum_we_d   = 1'b0;
    psum_addr_d = '0;
    acc_sel_d   = 1'b0;
    rst_psum_d  = 1'b0;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          s_m1_d   = i_cfg_s_m1;
          p_m1_d   = i_cfg_p_m1;
          acc_en_d = i_cfg_acc_en;
          wtgt_d   = i_cfg_wght_reuse ? '0 : WCW'(cfg_prod);
          icnt_d   = '0;
          wcnt_d   = '0;
          pcnt_d   = '0;
          lcnt_d   = '0;
          if (cfg_prod > EW'(2 ** WAB)) cfg_err_d = 1'b1;
          else                          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (i_ifmap_valid && o_ifmap_ready) begin
          ifmap_we_d = 1'b1;
          ifmap_wa_d = icnt_q[IAB-1:0];
          icnt_d     = icnt_q + 1'b1;
        end
        if (i_wght_valid && o_wght_ready) begin
          wght_we_d = 1'b1;
          wght_wa_d = wcnt_q[WAB-1:0];
          wcnt_d    = wcnt_q + 1'b1;
        end
        if (icnt_d == s_full && wcnt_d == wtgt_q) begin
          state_d = ST_CLEAR;
          pcnt_d  = '0;
        end
      end
      ST_CLEAR: begin
        psum_we_d   = 1'b1;
        rst_psum_d  = 1'b1;
        psum_addr_d = pcnt_q[PAB-1:0];
        pcnt_d      = pcnt_q + 1'b1;
        if (pcnt_q == p_last) begin
          state_d = ST_MAC;
          pcnt_d  = '0;
          icnt_d  = '0;
          wcnt_d  = '0;
        end
      end
      ST_MAC: begin
        if (pcnt_q <= p_last) begin
          ifmap_ra_d  = icnt_q[IAB-1:0];
          wght_ra_d   = wcnt_q[WAB-1:0];
          psum_we_d   = 1'b1;
          psum_addr_d = pcnt_q[PAB-1:0];
          wcnt_d      = wcnt_q + WCW'(s_full);
        end
        if (pcnt_q == slot_last) begin
          pcnt_d = '0;
          wcnt_d = WCW'(icnt_q) + 1'b1;
          icnt_d = icnt_q + 1'b1;
          if (icnt_q == SCW'(s_m1_q)) begin
            state_d = ST_DRAIN;
            lcnt_d  = '0;
          end
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      ST_DRAIN, ST_DRAIN2: begin
        lcnt_d = lcnt_q + 1'b1;
        if (lcnt_q == LCW'(PIPE_LAT - 1)) begin
          lcnt_d = '0;
          pcnt_d = '0;
          if (state_q == ST_DRAIN && acc_en_q) begin
            state_d = ST_ACC;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_ACC: begin
        if (o_psum_in_ready) begin
          acc_sel_d   = 1'b1;
          psum_addr_d = pcnt_q[PAB-1:0];
          pcnt_d      = pcnt_q + 1'b1;
          if (pcnt_q == p_last) begin
            state_d = ST_DRAIN2;
            lcnt_d  = '0;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      s_m1_q      <= '0;
      p_m1_q      <= '0;
      acc_en_q    <= 1'b0;
      wtgt_q      <= '0;
      icnt_q      <= '0;
      wcnt_q      <= '0;
      pcnt_q      <= '0;
      lcnt_q      <= '0;
      ifmap_we_q  <= 1'b0;
      ifmap_wa_q  <= '0;
      ifmap_ra_q  <= '0;
      wght_we_q   <= 1'b0;
      wght_wa_q   <= '0;
      wght_ra_q   <= '0;
      psum_we_q   <= 1'b0;
      psum_addr_q <= '0;
      acc_sel_q   <= 1'b0;
      rst_psum_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_m1_q      <= s_m1_d;
      p_m1_q      <= p_m1_d;
      acc_en_q    <= acc_en_d;
      wtgt_q      <= wtgt_d;
      icnt_q      <= icnt_d;
      wcnt_q      <= wcnt_d;
      pcnt_q      <= pcnt_d;
      lcnt_q      <= lcnt_d;
      ifmap_we_q  <= ifmap_we_d;
      ifmap_wa_q  <= ifmap_wa_d;
      ifmap_ra_q  <= ifmap_ra_d;
      wght_we_q   <= wght_we_d;
      wght_wa_q   <= wght_wa_d;
      wght_ra_q   <= wght_ra_d;
      psum_we_q   <= psum_we_d;
      psum_addr_q <= psum_addr_d;
      acc_sel_q   <= acc_sel_d;
      rst_psum_q  <= rst_psum_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign o_ifmap_we = ifmap_we_q;
  assign o_ifmap_wa = ifmap_wa_q;
  assign o_ifmap_ra = ifmap_ra_q;
  assign o_wght_we  = wght_we_q;
  assign o_wght_wa  = wght_wa_q;
  assign o_wght_ra  = wght_ra_q;
  assign o_psum_we  = psum_we_q;
  assign o_psum_wa  = psum_addr_q;
  assign o_psum_ra  = psum_addr_q;
  assign o_acc_sel  = acc_sel_q;
  assign o_rst_psum = rst_psum_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Bench for pe_seq_ctrl: job table plus corner sequences, with a scoreboard and a behavioural spad/MAC model.
module tb_pe_seq_ctrl;
  localparam int IAB = 4, WAB = 7, PAB = 4, PL = 4;

  logic           i_clk = 1'b0;
  logic           i_rst, i_start, i_cfg_wght_reuse, i_cfg_acc_en;
  logic [IAB-1:0] i_cfg_s_m1;
  logic [PAB-1:0] i_cfg_p_m1;
  logic           i_ifmap_valid, i_wght_valid, i_psum_in_valid, i_psum_out_ready;
  logic           o_ifmap_ready, o_wght_ready, o_psum_in_ready;
  logic           o_ifmap_we, o_wght_we, o_psum_we, o_acc_sel, o_rst_psum, o_busy, o_done, o_cfg_err;
  logic [IAB-1:0] o_ifmap_wa, o_ifmap_ra;
  logic [WAB-1:0] o_wght_wa, o_wght_ra;
  logic [PAB-1:0] o_psum_wa, o_psum_ra;

  always #5 i_clk = ~i_clk;

  pe_seq_ctrl #(.IFMAP_ADDR_BITWIDTH(IAB), .WGHT_ADDR_BITWIDTH(WAB),
                .PSUM_ADDR_BITWIDTH(PAB), .PIPE_LAT(PL)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .i_cfg_s_m1(i_cfg_s_m1), .i_cfg_p_m1(i_cfg_p_m1),
    .i_cfg_wght_reuse(i_cfg_wght_reuse), .i_cfg_acc_en(i_cfg_acc_en),
    .i_ifmap_valid(i_ifmap_valid), .o_ifmap_ready(o_ifmap_ready),
    .i_wght_valid(i_wght_valid), .o_wght_ready(o_wght_ready),
    .i_psum_in_valid(i_psum_in_valid), .o_psum_in_ready(o_psum_in_ready),
    .i_psum_out_ready(i_psum_out_ready),
    .o_ifmap_we(o_ifmap_we), .o_wght_we(o_wght_we), .o_psum_we(o_psum_we),
    .o_ifmap_wa(o_ifmap_wa), .o_ifmap_ra(o_ifmap_ra),
    .o_wght_wa(o_wght_wa), .o_wght_ra(o_wght_ra),
    .o_psum_wa(o_psum_wa), .o_psum_ra(o_psum_ra),
    .o_acc_sel(o_acc_sel), .o_rst_psum(o_rst_psum),
    .o_busy(o_busy), .o_done(o_done), .o_cfg_err(o_cfg_err));

  typedef struct { int ira; int wra; int pa; } iss_t;
  typedef struct { int s; int p; bit reuse; bit acc; bit stall; bit err; int exp_mac; } vec_t;

  int n_cmp = 0, n_bad = 0;
  int ifm_src[16], w_src[256], up_src[16];
  int ifm_mem[16], w_mem[128], psum_mem[16];
  int ifq[$], wq[$], upq[$], exp_acc_q[$];
  iss_t issq[$];
  int cyc = 0, issue_cnt, clear_cnt, done_cnt, err_cnt, in_rdy_cnt, ifm_hs, w_hs;
  int ifm_wr, w_wr, acc_cnt, first_issue, done_cyc;
  int last_iss[16];
  bit busy_seen, wrdy_seen, drv_stop;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard and spad/MAC model, sampled on the falling edge.
  always @(negedge i_clk) begin
    int k, up, res;
    iss_t e;
    cyc++;
    if (o_ifmap_we) begin
      chk("ifmap_we_expected", int'(ifq.size() > 0), 1);
      if (ifq.size() > 0) begin
        k = ifq.pop_front();
        chk("ifmap_wa", int'(o_ifmap_wa), k);
        ifm_mem[o_ifmap_wa] = ifm_src[k];
      end
      ifm_wr++;
    end
    if (o_wght_we) begin
      chk("wght_we_expected", int'(wq.size() > 0), 1);
      if (wq.size() > 0) begin
        k = wq.pop_front();
        chk("wght_wa", int'(o_wght_wa), k);
        w_mem[o_wght_wa] = w_src[k];
      end
      w_wr++;
    end
    if (o_psum_we && o_rst_psum) begin
      chk("clear_addr", int'(o_psum_wa), clear_cnt);
      psum_mem[o_psum_wa] = 0;
      clear_cnt++;
    end
    if (o_psum_we && !o_rst_psum) begin
      chk("mac_expected", int'(issq.size() > 0), 1);
      if (issq.size() > 0) begin
        e = issq.pop_front();
        chk("mac_ifmap_ra", int'(o_ifmap_ra), e.ira);
        chk("mac_wght_ra", int'(o_wght_ra), e.wra);
        chk("mac_psum_ra", int'(o_psum_ra), e.pa);
        chk("mac_psum_wa", int'(o_psum_wa), e.pa);
      end
      if (last_iss[o_psum_ra] >= 0) chk("hazard_gap_ok", int'(cyc - last_iss[o_psum_ra] >= PL), 1);
      last_iss[o_psum_ra] = cyc;
      if (issue_cnt == 0) first_issue = cyc;
      issue_cnt++;
      psum_mem[o_psum_wa] += ifm_mem[o_ifmap_ra] * w_mem[o_wght_ra];
    end
    if (o_acc_sel) begin
      chk("acc_expected", int'(upq.size() > 0 && exp_acc_q.size() > 0), 1);
      chk("acc_no_we", int'(o_psum_we), 0);
      chk("acc_ra", int'(o_psum_ra), acc_cnt);
      if (upq.size() > 0 && exp_acc_q.size() > 0) begin
        up = upq.pop_front();
        res = psum_mem[o_psum_ra] + up;
        chk("acc_out", res, exp_acc_q.pop_front());
      end
      acc_cnt++;
    end
    if (o_done) begin done_cnt++; done_cyc = cyc; end
    if (o_cfg_err) err_cnt++;
    if (o_busy) busy_seen = 1'b1;
    if (o_wght_ready) wrdy_seen = 1'b1;
    if (i_ifmap_valid && o_ifmap_ready) begin ifq.push_back(ifm_hs); ifm_hs++; end
    if (i_wght_valid && o_wght_ready) begin wq.push_back(w_hs); w_hs++; end
    if (i_psum_in_valid && o_psum_in_ready) begin upq.push_back(up_src[in_rdy_cnt]); in_rdy_cnt++; end
  end

  task automatic run_job(input int s, input int p, input bit reuse, input bit acc, input bit stall,
                         input bit gap, input bit abort, input bit exp_err, input int exp_mac);
    int exp_ps[16];
    int tmo, gap_n;
    for (int k = 0; k < s; k++) ifm_src[k] = k + 1;
    if (!reuse) for (int k = 0; k < s * p && k < 256; k++) w_src[k] = k + 1;
    for (int k = 0; k < 16; k++) begin up_src[k] = 100 * (k + 1); last_iss[k] = -1000; end
    ifq.delete(); wq.delete(); upq.delete(); exp_acc_q.delete(); issq.delete();
    if (!exp_err) begin
      for (int pi = 0; pi < p; pi++) begin
        exp_ps[pi] = 0;
        for (int si = 0; si < s; si++) exp_ps[pi] += ifm_src[si] * w_src[pi * s + si];
        if (acc) exp_acc_q.push_back(exp_ps[pi] + up_src[pi]);
      end
      for (int si = 0; si < s; si++)
        for (int pi = 0; pi < p; pi++) issq.push_back('{si, pi * s + si, pi});
    end
    issue_cnt = 0; clear_cnt = 0; done_cnt = 0; err_cnt = 0; in_rdy_cnt = 0;
    ifm_hs = 0; w_hs = 0; ifm_wr = 0; w_wr = 0; acc_cnt = 0; first_issue = 0; done_cyc = 0;
    busy_seen = 1'b0; wrdy_seen = 1'b0; drv_stop = 1'b0;

    @(posedge i_clk); #1;
    i_cfg_s_m1 = IAB'(s - 1);
    i_cfg_p_m1 = PAB'(p - 1);
    i_cfg_wght_reuse = reuse;
    i_cfg_acc_en = acc;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    fork
      begin
        gap_n = 0;
        while (!drv_stop) begin
          i_ifmap_valid = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
          i_wght_valid  = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
          if (gap && in_rdy_cnt == 2 && gap_n < 2) begin
            i_psum_in_valid = 1'b0;
            gap_n++;
          end else begin
            i_psum_in_valid = acc;
          end
          @(posedge i_clk); #1;
        end
        i_ifmap_valid = 1'b0; i_wght_valid = 1'b0; i_psum_in_valid = 1'b0;
      end
      begin
        tmo = 0;
        while (done_cnt == 0 && err_cnt == 0 && !(abort && issue_cnt >= 3) && tmo < 6000) begin
          @(negedge i_clk);
          tmo++;
        end
        chk("job_timeout", int'(tmo >= 6000), 0);
        if (abort) begin
          i_rst = 1'b1;
          @(negedge i_clk);
          chk("abort_outputs_zero", int'(|{o_ifmap_we, o_wght_we, o_psum_we, o_ifmap_wa, o_ifmap_ra,
              o_wght_wa, o_wght_ra, o_psum_wa, o_psum_ra, o_acc_sel, o_rst_psum, o_done, o_cfg_err,
              o_ifmap_ready, o_wght_ready, o_psum_in_ready}), 0);
          chk("abort_busy", int'(o_busy), 0);
          i_rst = 1'b0;
        end
        repeat (4) @(negedge i_clk);
        drv_stop = 1'b1;
      end
    join
    @(negedge i_clk);

    if (abort) begin
      chk("abort_no_done", done_cnt, 0);
      chk("abort_idle_busy", int'(o_busy), 0);
    end else if (exp_err) begin
      chk("cfg_err_pulses", err_cnt, 1);
      chk("err_busy_seen", int'(busy_seen), 0);
      chk("err_done", done_cnt, 0);
    end else begin
      chk("done_pulses", done_cnt, 1);
      chk("cfg_err_pulses", err_cnt, 0);
      chk("ifmap_writes", ifm_wr, s);
      chk("wght_writes", w_wr, reuse ? 0 : p * s);
      chk("clear_cnt", clear_cnt, p);
      chk("mac_issues", issue_cnt, exp_mac);
      chk("mac_left", issq.size(), 0);
      for (int pi = 0; pi < p; pi++) chk("psum_value", psum_mem[pi], exp_ps[pi]);
      if (reuse) chk("wght_ready_seen", int'(wrdy_seen), 0);
      if (acc) begin
        chk("in_ready_pulses", in_rdy_cnt, p);
        chk("acc_outs", acc_cnt, p);
      end else begin
        chk("in_ready_pulses", in_rdy_cnt, 0);
        chk("mac_to_done_span", done_cyc - first_issue, s * ((p > PL) ? p : PL) + PL - 1);
      end
      chk("busy_after_done", int'(o_busy), 0);
    end
  endtask

  initial begin
    vec_t tbl[6];
    int lit[4];
    tbl[0] = '{3, 4, 1'b1, 1'b0, 1'b1, 1'b0, 12};
    tbl[1] = '{2, 1, 1'b0, 1'b0, 1'b0, 1'b0, 2};
    tbl[2] = '{5, 3, 1'b0, 1'b0, 1'b1, 1'b0, 15};
    tbl[3] = '{16, 16, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    tbl[4] = '{16, 8, 1'b0, 1'b0, 1'b1, 1'b0, 128};
    tbl[5] = '{4, 2, 1'b0, 1'b1, 1'b1, 1'b0, 8};
    lit[0] = 14; lit[1] = 32; lit[2] = 50; lit[3] = 68;

    i_rst = 1'b1; i_start = 1'b0; i_cfg_s_m1 = '0; i_cfg_p_m1 = '0;
    i_cfg_wght_reuse = 1'b0; i_cfg_acc_en = 1'b0;
    i_ifmap_valid = 1'b0; i_wght_valid = 1'b0; i_psum_in_valid = 1'b0; i_psum_out_ready = 1'b1;
    repeat (3) @(negedge i_clk);
    chk("reset_outputs_zero", int'(|{o_ifmap_we, o_wght_we, o_psum_we, o_ifmap_wa, o_ifmap_ra,
        o_wght_wa, o_wght_ra, o_psum_wa, o_psum_ra, o_acc_sel, o_rst_psum, o_done, o_cfg_err}), 0);
    chk("reset_busy", int'(o_busy), 0);
    chk("reset_readies", int'(|{o_ifmap_ready, o_wght_ready, o_psum_in_ready}), 0);
    i_rst = 1'b0;

    run_job(3, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12);
    for (int pi = 0; pi < 4; pi++) chk("psum_literal", psum_mem[pi], lit[pi]);

    for (int t = 0; t < 6; t++)
      run_job(tbl[t].s, tbl[t].p, tbl[t].reuse, tbl[t].acc, tbl[t].stall, 1'b0, 1'b0, tbl[t].err, tbl[t].exp_mac);

    // ACC with upstream valid dropped for two cycles mid-phase.
    run_job(3, 4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12);
    // Reset during MAC, then a clean job reusing the already loaded weights.
    run_job(3, 4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 12);
    run_job(3, 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12);
    for (int pi = 0; pi < 4; pi++) chk("psum_after_abort", psum_mem[pi], lit[pi]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
